ocp_bus_arbiter: RTL and testbench

// Two-master round-robin arbiter for the shared OCP slave port. Each master_ocp instance raises its

---
 rtl/ocp_bus_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ocp_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ocp_bus_arbiter.sv
// Two-master round-robin arbiter steering one OCP master onto the shared slave port.
// Latency: grant 1 cycle after request; 2-cycle turnaround (HANDOFF + IDLE) between grants.
// Backpressure: slave SCmdAccept/SResp pass straight back to the owner; a stalled slave trips the watchdog.
module ocp_bus_arbiter #(
    parameter int DATAWIDTH    = 8,
    parameter int ADDRESSWIDTH = 32,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    // master 0
    input  logic                    m0_req,
    input  logic [2:0]              m0_MCmd,
    input  logic [ADDRESSWIDTH-1:0] m0_MAddr,
    input  logic [DATAWIDTH-1:0]    m0_MData,
    input  logic                    m0_MDataValid,
    input  logic                    m0_MDataLast,
    input  logic                    m0_MRespAccept,
    output logic                    m0_SCmdAccept,
    output logic [1:0]              m0_SResp,
    output logic [DATAWIDTH-1:0]    m0_SData,
    output logic                    m0_SRespLast,
    // master 1
    input  logic                    m1_req,
    input  logic [2:0]              m1_MCmd,
    input  logic [ADDRESSWIDTH-1:0] m1_MAddr,
    input  logic [DATAWIDTH-1:0]    m1_MData,
    input  logic                    m1_MDataValid,
    input  logic                    m1_MDataLast,
    input  logic                    m1_MRespAccept,
    output logic                    m1_SCmdAccept,
    output logic [1:0]              m1_SResp,
    output logic [DATAWIDTH-1:0]    m1_SData,
    output logic                    m1_SRespLast,
    // slave side
    output logic [2:0]              MCmd,
    output logic [ADDRESSWIDTH-1:0] MAddr,
    output logic [DATAWIDTH-1:0]    MData,
    output logic                    MDataValid,
    output logic                    MDataLast,
    output logic                    MRespAccept,
    input  logic                    SCmdAccept,
    input  logic [1:0]              SResp,
    input  logic [DATAWIDTH-1:0]    SData,
    input  logic                    SRespLast,
    // status
    output logic                    gnt0,
    output logic                    gnt1,
    output logic                    timeout_err
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, HANDOFF} state_t;

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    state_t     ps;
    logic       last_gnt;
    logic       mask0;
    logic       mask1;
    logic [7:0] wdog;

    logic elig0;
    logic elig1;
    logic owner_req;
    logic progress;

    // A master that was timed out stays ineligible until it drops its request.
    assign elig0     = m0_req & ~mask0;
    assign elig1     = m1_req & ~mask1;
    assign owner_req = (ps == GNT1) ? m1_req : m0_req;
    assign progress  = SCmdAccept | (SResp != 2'b00);

    // Arbitration FSM with watchdog, masks and registered grant/error outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps          <= IDLE;
            last_gnt    <= 1'b1;
            mask0       <= 1'b0;
            mask1       <= 1'b0;
            wdog        <= 8'd0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            if (!m0_req) mask0 <= 1'b0;
            if (!m1_req) mask1 <= 1'b0;
            case (ps)
                IDLE: begin
                    // On a tie the master that did not own the bus last wins.
                    if (elig0 && (!elig1 || last_gnt)) begin
                        ps       <= GNT0;
                        gnt0     <= 1'b1;
                        last_gnt <= 1'b0;
                        wdog     <= 8'd0;
                    end else if (elig1) begin
                        ps       <= GNT1;
                        gnt1     <= 1'b1;
                        last_gnt <= 1'b1;
                        wdog     <= 8'd0;
                    end
                end
                GNT0, GNT1: begin
                    if (!owner_req) begin
                        // Voluntary release takes priority over a coincident timeout.
                        ps   <= HANDOFF;
                        gnt0 <= 1'b0;
                        gnt1 <= 1'b0;
                    end else if (progress) begin
                        wdog <= 8'd0;
                    end else if (wdog == TO_LIMIT) begin
                        ps          <= HANDOFF;
                        gnt0        <= 1'b0;
                        gnt1        <= 1'b0;
                        timeout_err <= 1'b1;
                        if (ps == GNT0) mask0 <= 1'b1;
                        else            mask1 <= 1'b1;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end
                HANDOFF: ps <= IDLE;
                default: ps <= IDLE;
            endcase
        end
    end

    // Steer the owning master to the slave and return slave responses only to it.
    always_comb begin
        MCmd          = 3'b000;
        MAddr         = '0;
        MData         = '0;
        MDataValid    = 1'b0;
        MDataLast     = 1'b0;
        MRespAccept   = 1'b0;
        m0_SCmdAccept = 1'b0;
        m0_SResp      = 2'b00;
        m0_SData      = '0;
        m0_SRespLast  = 1'b0;
        m1_SCmdAccept = 1'b0;
        m1_SResp      = 2'b00;
        m1_SData      = '0;
        m1_SRespLast  = 1'b0;
        if (ps == GNT0) begin
            MCmd          = m0_MCmd;
            MAddr         = m0_MAddr;
            MData         = m0_MData;
            MDataValid    = m0_MDataValid;
            MDataLast     = m0_MDataLast;
            MRespAccept   = m0_MRespAccept;
            m0_SCmdAccept = SCmdAccept;
            m0_SResp      = SResp;
            m0_SData      = SData;
            m0_SRespLast  = SRespLast;
        end else if (ps == GNT1) begin
            MCmd          = m1_MCmd;
            MAddr         = m1_MAddr;
            MData         = m1_MData;
            MDataValid    = m1_MDataValid;
            MDataLast     = m1_MDataLast;
            MRespAccept   = m1_MRespAccept;
            m1_SCmdAccept = SCmdAccept;
            m1_SResp      = SResp;
            m1_SData      = SData;
            m1_SRespLast  = SRespLast;
        end
    end

endmodule

// File: tb/tb_ocp_bus_arbiter.sv
// Bench for ocp_bus_arbiter: cycle tables, directed corner sequences, randomized run vs reference model.
// Watchdog limit is 4 so timeouts occur quickly.
// Inputs are driven 1 time unit after the rising edge and outputs compared there.
module tb_ocp_bus_arbiter;

    localparam int DW = 8;
    localparam int AW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    logic m0_req, m1_req;
    logic [2:0] m0_MCmd, m1_MCmd;
    logic [AW-1:0] m0_MAddr, m1_MAddr;
    logic [DW-1:0] m0_MData, m1_MData;
    logic m0_MDataValid, m0_MDataLast, m0_MRespAccept;
    logic m1_MDataValid, m1_MDataLast, m1_MRespAccept;
    logic m0_SCmdAccept, m1_SCmdAccept;
    logic [1:0] m0_SResp, m1_SResp;
    logic [DW-1:0] m0_SData, m1_SData;
    logic m0_SRespLast, m1_SRespLast;
    logic [2:0] MCmd;
    logic [AW-1:0] MAddr;
    logic [DW-1:0] MData;
    logic MDataValid, MDataLast, MRespAccept;
    logic SCmdAccept;
    logic [1:0] SResp;
    logic [DW-1:0] SData;
    logic SRespLast;
    logic gnt0, gnt1, timeout_err;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ocp_bus_arbiter #(.DATAWIDTH(DW), .ADDRESSWIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_MCmd(m0_MCmd), .m0_MAddr(m0_MAddr), .m0_MData(m0_MData),
        .m0_MDataValid(m0_MDataValid), .m0_MDataLast(m0_MDataLast), .m0_MRespAccept(m0_MRespAccept),
        .m0_SCmdAccept(m0_SCmdAccept), .m0_SResp(m0_SResp), .m0_SData(m0_SData), .m0_SRespLast(m0_SRespLast),
        .m1_req(m1_req), .m1_MCmd(m1_MCmd), .m1_MAddr(m1_MAddr), .m1_MData(m1_MData),
        .m1_MDataValid(m1_MDataValid), .m1_MDataLast(m1_MDataLast), .m1_MRespAccept(m1_MRespAccept),
        .m1_SCmdAccept(m1_SCmdAccept), .m1_SResp(m1_SResp), .m1_SData(m1_SData), .m1_SRespLast(m1_SRespLast),
        .MCmd(MCmd), .MAddr(MAddr), .MData(MData), .MDataValid(MDataValid), .MDataLast(MDataLast),
        .MRespAccept(MRespAccept), .SCmdAccept(SCmdAccept), .SResp(SResp), .SData(SData),
        .SRespLast(SRespLast), .gnt0(gnt0), .gnt1(gnt1), .timeout_err(timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        m0_req = 0; m1_req = 0;
        m0_MCmd = 0; m1_MCmd = 0; m0_MAddr = 0; m1_MAddr = 0; m0_MData = 0; m1_MData = 0;
        m0_MDataValid = 0; m0_MDataLast = 0; m0_MRespAccept = 0;
        m1_MDataValid = 0; m1_MDataLast = 0; m1_MRespAccept = 0;
        SCmdAccept = 0; SResp = 0; SData = 0; SRespLast = 0;
    endtask

    // Hold reset for two edges with busy-looking inputs, then check every output is quiet.
    task automatic do_reset();
        clear_inputs();
        rst = 1;
        m0_MCmd = 3'b101; m1_MCmd = 3'b110; m0_MAddr = 32'hDEAD_BEEF;
        SResp = 2'b11; SData = 8'hFF; SCmdAccept = 1;
        tick();
        tick();
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_MCmd", MCmd, 0);
        chk("rst_MAddr", MAddr, 0);
        chk("rst_m0_SResp", m0_SResp, 0);
        chk("rst_m1_SData", m1_SData, 0);
        clear_inputs();
        rst = 0;
    endtask

    typedef struct {
        logic       r0;
        logic       r1;
        logic       e_g0;
        logic       e_g1;
        logic [2:0] e_cmd;
    } vec_t;

    vec_t tbl[12];

    // reference model state
    int own, hand, last, stall;
    bit msk[2];
    bit rq[2];
    bit prog, exp_err, e0, e1;

    initial begin
        clear_inputs();
        rst = 1;
        do_reset();

        // ---- tie, handoff timing and round-robin 0,1,0,1 (slave always accepting) ----
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b001};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b001};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b000};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b000};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b010};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b010};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b001};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b000};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b000};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b010};
        m0_MCmd = 3'b001; m1_MCmd = 3'b010; SCmdAccept = 1;
        for (int i = 0; i < 12; i++) begin
            m0_req = tbl[i].r0;
            m1_req = tbl[i].r1;
            tick();
            chk($sformatf("tbl%0d_gnt0", i), gnt0, tbl[i].e_g0);
            chk($sformatf("tbl%0d_gnt1", i), gnt1, tbl[i].e_g1);
            chk($sformatf("tbl%0d_MCmd", i), MCmd, tbl[i].e_cmd);
            chk($sformatf("tbl%0d_terr", i), timeout_err, 0);
        end

        // ---- single request: grant one cycle later, responses only to m0 ----
        do_reset();
        m0_req = 1; m0_MCmd = 3'b001; m0_MAddr = 32'h1234_5678;
        SResp = 2'b01; SData = 8'hAA;
        #1;
        chk("single_pre_gnt0", gnt0, 0);
        tick();
        chk("single_gnt0", gnt0, 1);
        chk("single_MCmd", MCmd, 3'b001);
        chk("single_MAddr", MAddr, 32'h1234_5678);
        chk("single_m0_SResp", m0_SResp, 2'b01);
        chk("single_m0_SData", m0_SData, 8'hAA);
        chk("single_m1_SResp", m1_SResp, 0);
        chk("single_m1_SData", m1_SData, 0);

        // ---- m1 4-beat write burst with the slave accepting every beat ----
        do_reset();
        m1_req = 1;
        tick();
        chk("burst_gnt1", gnt1, 1);
        for (int b = 0; b < 4; b++) begin
            m1_MCmd = 3'b111; m1_MAddr = 32'h100 + b; m1_MData = 8'h30 + 8'(b);
            m1_MDataValid = 1; m1_MDataLast = (b == 3); SCmdAccept = 1;
            #1;
            chk($sformatf("burst%0d_MCmd", b), MCmd, 3'b111);
            chk($sformatf("burst%0d_MData", b), MData, 8'h30 + b);
            chk($sformatf("burst%0d_MAddr", b), MAddr, 32'h100 + b);
            chk($sformatf("burst%0d_MDataLast", b), MDataLast, (b == 3));
            chk($sformatf("burst%0d_m1_SCmdAccept", b), m1_SCmdAccept, 1);
            tick();
            chk($sformatf("burst%0d_terr", b), timeout_err, 0);
            chk($sformatf("burst%0d_gnt1", b), gnt1, 1);
        end
        // a few idle-but-progressing cycles past the limit still must not time out
        m1_MCmd = 0; m1_MDataValid = 0; m1_MDataLast = 0;
        for (int k = 0; k < 6; k++) begin
            SCmdAccept = (k % 2 == 0); SResp = (k % 2 == 0) ? 2'b00 : 2'b01;
            tick();
        end
        chk("burst_hold_gnt1", gnt1, 1);
        chk("burst_hold_terr", timeout_err, 0);

        // ---- watchdog: stalled slave revokes m0, m1 next, m0 masked until req drops ----
        do_reset();
        m0_req = 1; m1_req = 1;
        tick();
        chk("wd_gnt0", gnt0, 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("wd_wait%0d_terr", k), timeout_err, 0);
            chk($sformatf("wd_wait%0d_gnt0", k), gnt0, 1);
        end
        tick();
        chk("wd_terr_pulse", timeout_err, 1);
        chk("wd_gnt0_revoked", gnt0, 0);
        tick();
        chk("wd_terr_once", timeout_err, 0);
        tick();
        chk("wd_gnt1_next", gnt1, 1);
        m1_req = 0;
        tick(); tick(); tick();
        chk("wd_m0_masked", gnt0, 0);
        m0_req = 0;
        tick();
        chk("wd_m0_low", gnt0, 0);
        m0_req = 1;
        tick();
        chk("wd_m0_regrant", gnt0, 1);

        // ---- reset while m1 holds the bus ----
        do_reset();
        m1_req = 1; m1_MCmd = 3'b011; SResp = 2'b01;
        tick();
        chk("rstmid_gnt1", gnt1, 1);
        chk("rstmid_m1_SResp_pre", m1_SResp, 2'b01);
        rst = 1;
        tick();
        chk("rstmid_gnt1_off", gnt1, 0);
        chk("rstmid_MCmd", MCmd, 0);
        chk("rstmid_m1_SResp", m1_SResp, 0);
        rst = 0; m0_req = 1;
        tick();
        chk("rstmid_tie_m0", gnt0, 1);
        chk("rstmid_tie_not_m1", gnt1, 0);

        // ---- randomized traffic against the reference model ----
        do_reset();
        own = -1; hand = 0; last = 1; stall = 0; msk[0] = 0; msk[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) m0_req = ~m0_req;
            if ($urandom_range(7) == 0) m1_req = ~m1_req;
            m0_MCmd = 3'($urandom); m1_MCmd = 3'($urandom);
            m0_MAddr = $urandom; m1_MAddr = $urandom;
            m0_MData = 8'($urandom); m1_MData = 8'($urandom);
            SData = 8'($urandom);
            SCmdAccept = ($urandom_range(5) == 0);
            SResp = ($urandom_range(7) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            rq[0] = m0_req; rq[1] = m1_req;
            prog = SCmdAccept || (SResp != 2'b00);
            tick();
            exp_err = 0;
            if (own >= 0) begin
                if (!rq[own]) begin
                    own = -1; hand = 1;
                end else if (prog) begin
                    stall = 0;
                end else if (stall == TO) begin
                    msk[own] = 1; own = -1; hand = 1; exp_err = 1;
                end else begin
                    stall++;
                end
            end else if (hand != 0) begin
                hand = 0;
            end else begin
                e0 = rq[0] && !msk[0];
                e1 = rq[1] && !msk[1];
                if (e0 && e1) own = 1 - last;
                else if (e0)  own = 0;
                else if (e1)  own = 1;
                if (own >= 0) begin
                    last = own; stall = 0;
                end
            end
            for (int k = 0; k < 2; k++) if (!rq[k]) msk[k] = 0;

            chk("rnd_gnt0", gnt0, own == 0);
            chk("rnd_gnt1", gnt1, own == 1);
            chk("rnd_terr", timeout_err, exp_err);
            chk("rnd_MCmd", MCmd, (own == 0) ? m0_MCmd : (own == 1) ? m1_MCmd : 3'b000);
            chk("rnd_MAddr", MAddr, (own == 0) ? m0_MAddr : (own == 1) ? m1_MAddr : 32'h0);
            chk("rnd_MData", MData, (own == 0) ? m0_MData : (own == 1) ? m1_MData : 8'h0);
            chk("rnd_m0_SResp", m0_SResp, (own == 0) ? SResp : 2'b00);
            chk("rnd_m1_SData", m1_SData, (own == 1) ? SData : 8'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
